// File: rtl/fp_cmp_pkg.sv
// Shared fp_cmp definitions: binary32 field constants, the unpacked operand
// record and the unpack / flush-to-zero / NaN canonicalisation helpers.
package fp_cmp_pkg;

    localparam int          FP32_MAN_W    = 23;
    localparam int          FP32_EXP_W    = 8;
    localparam logic [7:0]  FP32_EXP_MAX  = 8'hFF;
    localparam logic [22:0] CANON_NAN_MAN = 23'h400000;

    typedef struct packed {
        logic                  sign;
        logic [FP32_EXP_W-1:0] exp;
        logic [FP32_MAN_W-1:0] man;
        logic                  nan;
    } fp32_fields_t;

    // True when this operand is a denormal that gets flushed.
    function automatic logic fp32_flushed(input logic [31:0] word, input logic ftz);
        return ftz && (word[30:23] == 8'h00) && (word[22:0] != 23'h000000);
    endfunction

    function automatic fp32_fields_t fp32_unpack(input logic [31:0] word,
                                                 input logic        ftz,
                                                 input logic        canon_nan);
        fp32_fields_t f;
        logic         is_nan;
        is_nan = (word[30:23] == FP32_EXP_MAX) && (word[22:0] != 23'h000000);
        f.exp  = word[30:23];
        f.nan  = is_nan;
        f.sign = (canon_nan && is_nan) ? 1'b0 : word[31];
        // Flush and canonicalisation are mutually exclusive: exp is 0 vs 0xFF.
        f.man  = fp32_flushed(word, ftz)  ? 23'h000000    :
                 (canon_nan && is_nan)    ? CANON_NAN_MAN : word[22:0];
        return f;
    endfunction

endpackage

// File: rtl/fp_cmp_unpack_if.sv
// Operand-pair input handshake plus the unpacked pair delivered to fp_cmp.
interface fp_cmp_unpack_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        src_valid;
    logic [22:0] a_man;
    logic [7:0]  a_exp;
    logic        a_sign;
    logic [22:0] b_man;
    logic [7:0]  b_exp;
    logic        b_sign;
    logic        a_nan;
    logic        b_nan;

    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, src_valid, a_man, a_exp, a_sign,
               b_man, b_exp, b_sign, a_nan, b_nan
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, src_valid, a_man, a_exp, a_sign,
               b_man, b_exp, b_sign, a_nan, b_nan
    );

endinterface

// File: rtl/fp_cmp_fifo.sv
// Generic synchronous FIFO with occupancy count; DEPTH must be a power of two.
module fp_cmp_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wptr_r;
    logic [AW-1:0]    rptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && (count_r != (AW+1)'(DEPTH));
    assign pop_ok_s  = pop && (count_r != '0);
    assign head      = mem_r[rptr_r];
    assign count     = count_r;

    // Storage array; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wptr_r] <= wdata;
        end else begin
            mem_r[wptr_r] <= mem_r[wptr_r];
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_ok_s) begin
                wptr_r <= wptr_r + AW'(1);
            end else begin
                wptr_r <= wptr_r;
            end
            if (pop_ok_s) begin
                rptr_r <= rptr_r + AW'(1);
            end else begin
                rptr_r <= rptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fp_cmp_unpack.sv
// fp_cmp operand stage: unpacks binary32 pairs on write into a small FIFO and
// presents the head pair to fp_cmp through a registered output stage.
module fp_cmp_unpack
    import fp_cmp_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter bit FTZ       = 1'b1,
    parameter bit CANON_NAN = 1'b1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    input  logic               clr_cnt,
    output logic [15:0]        ftz_cnt,
    fp_cmp_unpack_if.slave     bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = $bits(fp32_fields_t);

    fp32_fields_t   a_unp_s;
    fp32_fields_t   b_unp_s;
    fp32_fields_t   a_head_s;
    fp32_fields_t   b_head_s;
    fp32_fields_t   a_out_r;
    fp32_fields_t   b_out_r;
    logic           src_valid_r;
    logic [15:0]    ftz_cnt_r;
    logic [CW-1:0]  count_s;
    logic           in_ready_s;
    logic           push_s;
    logic           pop_s;
    logic [1:0]     nflush_s;
    logic [16:0]    cnt_sum_s;
    logic [2*FW-1:0] head_s;

    assign in_ready_s = (count_s != CW'(DEPTH));
    assign push_s     = bus.in_valid && in_ready_s;
    assign pop_s      = enable && (count_s != '0);

    // Split, flush and canonicalise both operands ahead of the FIFO write.
    always_comb begin
        a_unp_s   = fp32_unpack(bus.in_a, FTZ, CANON_NAN);
        b_unp_s   = fp32_unpack(bus.in_b, FTZ, CANON_NAN);
        nflush_s  = {1'b0, fp32_flushed(bus.in_a, FTZ)} + {1'b0, fp32_flushed(bus.in_b, FTZ)};
        cnt_sum_s = {1'b0, ftz_cnt_r} + {15'd0, nflush_s};
    end

    fp_cmp_fifo #(
        .WIDTH (2*FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_s),
        .wdata ({a_unp_s, b_unp_s}),
        .pop   (pop_s),
        .head  (head_s),
        .count (count_s)
    );

    assign a_head_s = head_s[2*FW-1:FW];
    assign b_head_s = head_s[FW-1:0];

    // Output stage: advances only with enable; fields hold when nothing pops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            src_valid_r <= 1'b0;
            a_out_r     <= '0;
            b_out_r     <= '0;
        end else if (enable) begin
            if (pop_s) begin
                src_valid_r <= 1'b1;
                a_out_r     <= a_head_s;
                b_out_r     <= b_head_s;
            end else begin
                src_valid_r <= 1'b0;
                a_out_r     <= a_out_r;
                b_out_r     <= b_out_r;
            end
        end else begin
            src_valid_r <= src_valid_r;
            a_out_r     <= a_out_r;
            b_out_r     <= b_out_r;
        end
    end

    // Saturating flush counter; a clear wins over that cycle's increment.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ftz_cnt_r <= 16'h0000;
        end else if (clr_cnt) begin
            ftz_cnt_r <= 16'h0000;
        end else if (push_s) begin
            ftz_cnt_r <= cnt_sum_s[16] ? 16'hFFFF : cnt_sum_s[15:0];
        end else begin
            ftz_cnt_r <= ftz_cnt_r;
        end
    end

    assign ftz_cnt       = ftz_cnt_r;
    assign bus.in_ready  = in_ready_s;
    assign bus.src_valid = src_valid_r;
    assign bus.a_sign    = a_out_r.sign;
    assign bus.a_exp     = a_out_r.exp;
    assign bus.a_man     = a_out_r.man;
    assign bus.a_nan     = a_out_r.nan;
    assign bus.b_sign    = b_out_r.sign;
    assign bus.b_exp     = b_out_r.exp;
    assign bus.b_man     = b_out_r.man;
    assign bus.b_nan     = b_out_r.nan;

endmodule
